opcode_scheduler: RTL

Shares one opcode_processor-style datapath (4-bit opcode, 8-bit data, 1-cycle registered result) between two requesters. Per-requester valid/ready command ports; round-robin arbitration; one operation in flight at a time. Drives the datapath's opcode/data inputs, captures its result at the correct cycle, and returns it tagged with the requester ID.

---
 rtl/opcode_scheduler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/opcode_scheduler.sv
// Two-requester round-robin front end for a shared single-cycle opcode datapath.
// Define OPCODE_FILTER_EN to answer opcodes 4'b1001..4'b1110 with ERR_DATA instead of issuing them.
module opcode_scheduler #(
  parameter logic [3:0] NOP_OPCODE = 4'b0010,
  parameter logic [7:0] ERR_DATA   = 8'hEE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  input  logic [3:0] req_opcode0,
  input  logic [7:0] req_data0,
  input  logic [3:0] req_opcode1,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ready,
  output logic [3:0] proc_opcode,
  output logic [7:0] proc_data,
  input  logic [7:0] proc_result,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [7:0] resp_data,
  output logic       resp_err,
  input  logic       resp_ready,
  output logic       busy
);

  localparam logic [3:0] LOAD_OPCODE = 4'b0001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  lat_op_q, lat_op_d;
  logic [7:0]  lat_data_q, lat_data_d;
  logic        lat_id_q, lat_id_d;
  logic [3:0]  proc_opcode_q, proc_opcode_d;
  logic [7:0]  proc_data_q, proc_data_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic [7:0]  resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        gnt_vld;
  logic        gnt_id;
  logic [3:0]  sel_op;
  logic [7:0]  sel_data;
  logic        sel_reject;

  // Round-robin: on a tie the requester that was not served last wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (state_q == S_IDLE) begin
      case (req_valid)
        2'b01:   begin gnt_vld = 1'b1; gnt_id = 1'b0;    end
        2'b10:   begin gnt_vld = 1'b1; gnt_id = 1'b1;    end
        2'b11:   begin gnt_vld = 1'b1; gnt_id = ~last_q; end
        default: begin gnt_vld = 1'b0; gnt_id = 1'b0;    end
      endcase
    end
  end

  assign req_ready = {gnt_vld & gnt_id, gnt_vld & ~gnt_id};
  assign sel_op    = gnt_id ? req_opcode1 : req_opcode0;
  assign sel_data  = gnt_id ? req_data1   : req_data0;

`ifdef OPCODE_FILTER_EN
  assign sel_reject = (sel_op >= 4'b1001) && (sel_op <= 4'b1110);
`else
  assign sel_reject = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    lat_op_d      = lat_op_q;
    lat_data_d    = lat_data_q;
    lat_id_d      = lat_id_q;
    proc_opcode_d = proc_opcode_q;
    proc_data_d   = proc_data_q;
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_data_d   = resp_data_q;
    resp_err_d    = resp_err_q;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          lat_op_d   = sel_op;
          lat_data_d = sel_data;
          lat_id_d   = gnt_id;
          last_d     = gnt_id;
          if (sel_reject) begin
            // Rejected opcodes never touch the datapath; answer straight away.
            resp_valid_d = 1'b1;
            resp_id_d    = gnt_id;
            resp_data_d  = ERR_DATA;
            resp_err_d   = 1'b1;
            state_d      = S_RESP;
          end else begin
            proc_opcode_d = sel_op;
            proc_data_d   = sel_data;
            state_d       = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        proc_opcode_d = NOP_OPCODE;
        proc_data_d   = '0;
        state_d       = S_CAPTURE;
      end
      S_CAPTURE: begin
        // LOAD leaves the datapath result untouched, so echo the loaded value.
        resp_valid_d = 1'b1;
        resp_id_d    = lat_id_q;
        resp_data_d  = (lat_op_q == LOAD_OPCODE) ? lat_data_q : proc_result;
        resp_err_d   = 1'b0;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      last_q        <= 1'b1;
      lat_op_q      <= NOP_OPCODE;
      lat_data_q    <= '0;
      lat_id_q      <= 1'b0;
      proc_opcode_q <= NOP_OPCODE;
      proc_data_q   <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      lat_op_q      <= lat_op_d;
      lat_data_q    <= lat_data_d;
      lat_id_q      <= lat_id_d;
      proc_opcode_q <= proc_opcode_d;
      proc_data_q   <= proc_data_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_data_q   <= resp_data_d;
      resp_err_q    <= resp_err_d;
    end
  end

  assign proc_opcode = proc_opcode_q;
  assign proc_data   = proc_data_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_data   = resp_data_q;
  assign resp_err    = resp_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule
